des_f_function: RTL

DES_F_FUNCTION -- requirements
Module: des_f_function

---
 rtl/des_pkg.sv | 72 +++++++
 rtl/des_sbox_bank.sv | 53 +++++
 rtl/des_f_function.sv | 119 +++++++++++
 3 files changed

// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Brief    : Shared DES f-function constants (E, P, standard S-boxes) and
//            bit-permutation helpers. DES bit 1 is the MSB of every vector.
// Revision : 1.0
// ============================================================================
package des_pkg;

    localparam int R_W     = 32;
    localparam int K_W     = 48;
    localparam int CHUNK_W = 6;
    localparam int N_SBOX  = 8;

    typedef struct packed {
        logic [2:0] sel;
        logic [1:0] row;
        logic [3:0] col;
        logic [3:0] val;
    } sbox_edit_t;

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    // One 256-bit word per box, rows 0..3 in order, entry (row,col) at nibble row*16+col from the MSB.
    localparam logic [255:0] SBOX_STD [N_SBOX] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [K_W-1:0] des_expand(input logic [R_W-1:0] r);
        logic [K_W-1:0] e;
        e = '0;
        for (int i = 0; i < K_W; i++) begin
            e[6'(K_W-1-i)] = r[5'(R_W-E_TBL[i])];
        end
        return e;
    endfunction

    function automatic logic [R_W-1:0] des_permute(input logic [R_W-1:0] s);
        logic [R_W-1:0] f;
        f = '0;
        for (int i = 0; i < R_W; i++) begin
            f[5'(R_W-1-i)] = s[5'(R_W-P_TBL[i])];
        end
        return f;
    endfunction

    // idx = {row, col}; nibble idx sits at bit 255-4*idx, i.e. {~idx, 2'b11}.
    function automatic logic [3:0] des_sbox_std(input logic [2:0] n, input logic [5:0] idx);
        logic [255:0] tbl;
        tbl = SBOX_STD[n];
        return tbl[{~idx, 2'b11} -: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_sbox_bank.sv
`default_nettype none
// ============================================================================
// Module   : des_sbox_bank
// Brief    : Eight DES S-box lookups on a 48-bit chunked word. Tables are
//            writable when DES_SBOX_EDIT_EN is defined, fixed otherwise.
// Revision : 1.0
// ============================================================================
module des_sbox_bank
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [K_W-1:0]   i_x,
    input  logic             i_edit_we,
    input  logic [2:0]       i_edit_sel,
    input  logic [1:0]       i_edit_row,
    input  logic [3:0]       i_edit_col,
    input  logic [3:0]       i_edit_val,
    output logic [R_W-1:0]   o_sout
);

`ifdef DES_SBOX_EDIT_EN
    logic [3:0] r_tbl [N_SBOX][64];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N_SBOX; n++) begin
                for (int i = 0; i < 64; i++) begin
                    r_tbl[n][i] <= des_sbox_std(3'(n), 6'(i));
                end
            end
        end else if (i_edit_we) begin
            r_tbl[i_edit_sel][{i_edit_row, i_edit_col}] <= i_edit_val;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{clk, rst_n, i_edit_we, i_edit_sel, i_edit_row, i_edit_col, i_edit_val};
`endif

    for (genvar n = 0; n < N_SBOX; n++) begin : g_box
        logic [5:0] w_idx;
        // Row comes from the outer chunk bits, column from the inner four.
        assign w_idx = {i_x[K_W-1-CHUNK_W*n], i_x[K_W-CHUNK_W*(n+1)], i_x[K_W-2-CHUNK_W*n -: 4]};
`ifdef DES_SBOX_EDIT_EN
        assign o_sout[R_W-1-4*n -: 4] = r_tbl[n][w_idx];
`else
        assign o_sout[R_W-1-4*n -: 4] = des_sbox_std(3'(n), w_idx);
`endif
    end

endmodule
`default_nettype wire

// File: rtl/des_f_function.sv
`default_nettype none
// ============================================================================
// Module   : des_f_function
// Brief    : Two-stage valid/ready DES round function f(R,K) = P(S(E(R)^K)).
//            Define DES_SBOX_EDIT_EN to enable runtime S-box entry rewrites.
// Revision : 1.0
// ============================================================================
module des_f_function
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [R_W-1:0]   i_r,
    input  logic [K_W-1:0]   i_subkey,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [R_W-1:0]   o_f,
    input  logic             edit_sbox,
    input  logic [2:0]       sbox_sel,
    input  logic [1:0]       row_sel,
    input  logic [3:0]       col_sel,
    input  logic [3:0]       new_sbox_val,
    output logic             o_edit_ack,
    output logic             o_busy
);

    logic             r_s1_valid;
    logic [K_W-1:0]   r_s1_x;
    logic             r_o_valid;
    logic [R_W-1:0]   r_o_f;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic             w_in_xfer;
    logic             w_edit_block;
    logic             w_edit_we;
    sbox_edit_t       w_edit;
    logic [R_W-1:0]   w_sout;

    assign w_s2_adv  = !r_o_valid || i_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign o_ready   = w_s1_adv && !w_edit_block;
    assign w_in_xfer = i_valid && o_ready;
    assign o_busy    = r_s1_valid || r_o_valid;
    assign o_valid   = r_o_valid;
    assign o_f       = r_o_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_o_valid  <= 1'b0;
            r_o_f      <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_in_xfer;
                if (w_in_xfer) begin
                    r_s1_x <= des_expand(i_r) ^ i_subkey;
                end
            end
            if (w_s2_adv) begin
                r_o_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_o_f <= des_permute(w_sout);
                end
            end
        end
    end

`ifdef DES_SBOX_EDIT_EN
    sbox_edit_t r_edit;
    logic       r_edit_pend;
    logic       r_edit_ack;

    // A raw edit request also blocks o_ready so the edit wins without breaking the handshake.
    assign w_edit_block = r_edit_pend || edit_sbox;
    assign w_edit_we    = r_edit_pend && !o_busy;
    assign w_edit       = r_edit;
    assign o_edit_ack   = r_edit_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edit      <= '0;
            r_edit_pend <= 1'b0;
            r_edit_ack  <= 1'b0;
        end else begin
            r_edit_ack <= w_edit_we;
            if (w_edit_we) begin
                r_edit_pend <= 1'b0;
            end else if (edit_sbox && !r_edit_pend) begin
                r_edit_pend <= 1'b1;
                r_edit      <= {sbox_sel, row_sel, col_sel, new_sbox_val};
            end
        end
    end
`else
    logic w_unused_edit;
    assign w_unused_edit = ^{edit_sbox, sbox_sel, row_sel, col_sel, new_sbox_val};
    assign w_edit_block  = 1'b0;
    assign w_edit_we     = 1'b0;
    assign w_edit        = '0;
    assign o_edit_ack    = 1'b0;
`endif

    des_sbox_bank u_sbox_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_x        (r_s1_x),
        .i_edit_we  (w_edit_we),
        .i_edit_sel (w_edit.sel),
        .i_edit_row (w_edit.row),
        .i_edit_col (w_edit.col),
        .i_edit_val (w_edit.val),
        .o_sout     (w_sout)
    );

endmodule
`default_nettype wire
